// File: rtl/i2c_slave_regs.sv
// I2C target with a small register file shared between the I2C bus and a local host port.
// Optional define I2C_SLV_GLITCH_FILT_EN adds a 3-sample glitch filter on SCL/SDA.
module i2c_slave_regs #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    slave_addr,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  input  logic          loc_we,
  output logic [7:0]    loc_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic          busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StWait
  } state_e;

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_d, sda_d;
  logic          scl_q, sda_q;
  logic          scl_rise_q, scl_fall_q, sda_rise_q, sda_fall_q;
  logic          start_c, stop_c, commit;
  logic [7:0]    byte_in;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [7:0]    sh_q;
  logic [AW-1:0] ptr_q;
  logic          rw_q, ack_q;
  logic [7:0]    regs_q [DEPTH];

`ifdef I2C_SLV_GLITCH_FILT_EN
  logic [1:0] scl_hist_q, sda_hist_q;

  // Level only follows the synchroniser once three consecutive samples agree.
  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1]) scl_d = scl_sync_q[1];
    if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1]) sda_d = sda_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
    end
  end
`else
  assign scl_d = scl_sync_q[1];
  assign sda_d = sda_sync_q[1];
`endif

  // Synchronisers idle high so a released bus produces no spurious edges out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_rise_q <= 1'b0;
      sda_fall_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      scl_rise_q <= scl_d & ~scl_q;
      scl_fall_q <= ~scl_d & scl_q;
      sda_rise_q <= sda_d & ~sda_q;
      sda_fall_q <= ~sda_d & sda_q;
    end
  end

  assign start_c = sda_fall_q & scl_q;
  assign stop_c  = sda_rise_q & scl_q;
  assign byte_in = {sh_q[6:0], sda_q};
  assign commit  = !start_c && !stop_c && (state_q == StWdata) && scl_rise_q && (cnt_q == 3'd7);

  // Register file: an I2C commit overrides a local write to the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= 8'h00;
      loc_rdata <= 8'h00;
    end else begin
      if (loc_we && !(commit && loc_addr == ptr_q)) regs_q[loc_addr] <= loc_wdata;
      if (commit) regs_q[ptr_q] <= byte_in;
      if (commit && loc_addr == ptr_q) loc_rdata <= byte_in;
      else if (loc_we)                 loc_rdata <= loc_wdata;
      else                             loc_rdata <= regs_q[loc_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      sh_q      <= 8'h00;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_c) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (start_c) begin
        state_q <= StAddr;
        cnt_q   <= 3'd0;
        ack_q   <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StWait: ;
          StAddr: if (scl_rise_q) begin
            sh_q  <= byte_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == slave_addr) begin
                state_q <= StAddrAck;
                busy    <= 1'b1;
                rw_q    <= byte_in[0];
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end
          end
          // First SCL fall drives ACK, the following fall ends the ACK slot.
          StAddrAck, StPtrAck, StWdataAck: if (scl_fall_q) begin
            if (!ack_q) begin
              sda_oe <= 1'b1;
              ack_q  <= 1'b1;
            end else begin
              ack_q <= 1'b0;
              cnt_q <= 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                sh_q    <= regs_q[ptr_q];
                sda_oe  <= ~regs_q[ptr_q][7];
                state_q <= StRdata;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= (state_q == StAddrAck) ? StPtr : StWdata;
              end
            end
          end
          StPtr: if (scl_rise_q) begin
            sh_q  <= byte_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_q   <= byte_in[AW-1:0];
              state_q <= StPtrAck;
            end
          end
          StWdata: if (scl_rise_q) begin
            sh_q  <= byte_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wr_strobe <= 1'b1;
              wr_addr   <= ptr_q;
              ptr_q     <= ptr_q + {{(AW-1){1'b0}}, 1'b1};
              state_q   <= StWdataAck;
            end
          end
          // Counter wraps to 0 after the 8th rise, so the next fall ends the byte.
          StRdata: begin
            if (scl_rise_q) begin
              cnt_q <= cnt_q + 3'd1;
            end else if (scl_fall_q) begin
              if (cnt_q == 3'd0) begin
                sda_oe  <= 1'b0;
                ptr_q   <= ptr_q + {{(AW-1){1'b0}}, 1'b1};
                state_q <= StRdataAck;
              end else begin
                sda_oe <= ~sh_q[6];
                sh_q   <= {sh_q[6:0], 1'b0};
              end
            end
          end
          StRdataAck: begin
            if (scl_rise_q) begin
              if (sda_q) state_q <= StWait;
              else       ack_q   <= 1'b1;
            end else if (scl_fall_q && ack_q) begin
              ack_q   <= 1'b0;
              cnt_q   <= 3'd0;
              sh_q    <= regs_q[ptr_q];
              sda_oe  <= ~regs_q[ptr_q][7];
              state_q <= StRdata;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master plus a write-commit scoreboard.
module tb_i2c_slave_regs;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] slave_addr = 7'h10;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] loc_wdata = 8'h00;
  logic       loc_we = 1'b0;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         oe_cnt = 0;
  bit         no_oe = 1'b0;
  logic [3:0] exp_wr_q[$];

  always #5 clk = ~clk;
  assign sda_i = sda_m & ~sda_oe;

  i2c_slave_regs #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .slave_addr(slave_addr), .scl_i(scl_m), .sda_i(sda_i),
    .sda_oe(sda_oe), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we),
    .loc_rdata(loc_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  // Scoreboard monitor: every commit strobe must match the next expected address.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (no_oe && sda_oe) oe_cnt++;
      if (wr_strobe) begin
        vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_strobe_unexpected: got wr_addr=%0d, expected no strobe", wr_addr);
        end else begin
          e = exp_wr_q.pop_front();
          if (wr_addr !== e) begin
            miscompares++;
            $display("FAIL wr_addr: got %0d, expected %0d", wr_addr, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  // coll: pulse loc_we in the exact cycle the slave commits the 8th bit.
  task automatic write_byte(input logic [7:0] b, input bit coll, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); sda_m = b[i]; tick(Q); scl_m = 1'b1;
      if (coll && i == 0) begin
        tick(3); loc_we = 1'b1; tick(1); loc_we = 1'b0; tick(2*Q - 4);
      end else begin
        tick(2*Q);
      end
      scl_m = 1'b0;
    end
    tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); ack = sda_i; tick(Q); scl_m = 1'b0;
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b[i] = sda_i; tick(Q); scl_m = 1'b0;
    end
    tick(Q); sda_m = nack; tick(Q); scl_m = 1'b1; tick(Q);
    if (nack) check("nack_bit_sda_oe", sda_oe, 1'b0);
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic loc_rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    loc_addr = a; tick(1);
    check(name, loc_rdata, exp);
  endtask

  task automatic wr_addr_byte(input logic [7:0] b, input string name);
    logic ack;
    write_byte(b, 1'b0, ack);
    check(name, ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         oe_start;

    tick(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 4'd0);
    check("rst_loc_rdata", loc_rdata, 8'h00);
    rst = 1'b1;
    tick(4);

    // Write 0xA5 to reg 6
    i2c_start();
    wr_addr_byte(8'h20, "wr_addr_ack");
    wr_addr_byte(8'h06, "wr_ptr_ack");
    exp_wr_q.push_back(4'd6);
    wr_addr_byte(8'hA5, "wr_data_ack");
    check("busy_in_xfer", busy, 1'b1);
    i2c_stop();
    check("busy_after_stop", busy, 1'b0);
    loc_rd(4'd6, 8'hA5, "reg6_after_write");

    // Pointer must now be 7: current-address read returns reg 7
    loc_addr = 4'd7; loc_wdata = 8'h77; loc_we = 1'b1; tick(1); loc_we = 1'b0;
    i2c_start();
    wr_addr_byte(8'h21, "cur_rd_addr_ack");
    read_byte(1'b1, rd);
    check("cur_rd_data_reg7", rd, 8'h77);
    check("busy_after_nack", busy, 1'b1);
    i2c_stop();
    check("busy_after_rd_stop", busy, 1'b0);

    // Pointer write, repeated start, read back 0xA5
    i2c_start();
    wr_addr_byte(8'h20, "rd_addr_w_ack");
    wr_addr_byte(8'h06, "rd_ptr_ack");
    i2c_rstart();
    wr_addr_byte(8'h21, "rd_addr_r_ack");
    read_byte(1'b1, rd);
    check("rd_data_reg6", rd, 8'hA5);
    i2c_stop();
    check("sda_oe_after_read", sda_oe, 1'b0);

    // Address mismatch: no ACK, no drive, no writes
    oe_start = oe_cnt;
    no_oe = 1'b1;
    i2c_start();
    write_byte(8'h22, 1'b0, ack);
    check("mismatch_addr_nack", ack, 1'b1);
    check("mismatch_busy", busy, 1'b0);
    write_byte(8'h55, 1'b0, ack);
    check("mismatch_data_nack", ack, 1'b1);
    i2c_stop();
    no_oe = 1'b0;
    check("mismatch_sda_oe_cycles", oe_cnt - oe_start, 0);
    loc_rd(4'd5, 8'h00, "mismatch_reg5");
    loc_rd(4'd6, 8'hA5, "mismatch_reg6");

    // Pointer wrap 15 -> 0
    i2c_start();
    wr_addr_byte(8'h20, "wrap_addr_ack");
    wr_addr_byte(8'h0F, "wrap_ptr_ack");
    exp_wr_q.push_back(4'd15);
    wr_addr_byte(8'h11, "wrap_d0_ack");
    exp_wr_q.push_back(4'd0);
    wr_addr_byte(8'h22, "wrap_d1_ack");
    i2c_stop();
    loc_rd(4'd15, 8'h11, "wrap_reg15");
    loc_rd(4'd0, 8'h22, "wrap_reg0");

    // Collision on the same register: I2C wins
    loc_addr = 4'd6; loc_wdata = 8'h3C;
    i2c_start();
    wr_addr_byte(8'h20, "coll_same_addr_ack");
    wr_addr_byte(8'h06, "coll_same_ptr_ack");
    exp_wr_q.push_back(4'd6);
    write_byte(8'h5A, 1'b1, ack);
    check("coll_same_data_ack", ack, 1'b0);
    i2c_stop();
    loc_rd(4'd6, 8'h5A, "coll_same_reg6");

    // Collision on different registers: both land
    loc_addr = 4'd5; loc_wdata = 8'h3C;
    i2c_start();
    wr_addr_byte(8'h20, "coll_diff_addr_ack");
    wr_addr_byte(8'h06, "coll_diff_ptr_ack");
    exp_wr_q.push_back(4'd6);
    write_byte(8'h5A, 1'b1, ack);
    check("coll_diff_data_ack", ack, 1'b0);
    i2c_stop();
    loc_rd(4'd5, 8'h3C, "coll_diff_reg5");
    loc_rd(4'd6, 8'h5A, "coll_diff_reg6");

    // Reset while driving bit 7 (0) of reg 6 = 0x5A
    i2c_start();
    wr_addr_byte(8'h20, "rstrd_addr_w_ack");
    wr_addr_byte(8'h06, "rstrd_ptr_ack");
    i2c_rstart();
    wr_addr_byte(8'h21, "rstrd_addr_r_ack");
    tick(Q);
    check("rstrd_sda_oe_driving", sda_oe, 1'b1);
    rst = 1'b0;
    tick(1);
    check("rstrd_sda_oe_released", sda_oe, 1'b0);
    tick(2);
    rst = 1'b1;
    check("rstrd_busy", busy, 1'b0);
    tick(2);
    i2c_stop();
    i2c_start();
    wr_addr_byte(8'h21, "post_rst_addr_ack");
    read_byte(1'b1, rd);
    check("post_rst_rd_data", rd, 8'h00);
    i2c_stop();
    loc_rd(4'd6, 8'h00, "post_rst_reg6");
    loc_rd(4'd5, 8'h00, "post_rst_reg5");

    tick(Q);
    check("pending_wr_strobes", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
